// File: rtl/ex_stage.sv
// MIPS32 execute stage: operand forwarding, ALU/shifter, iterative shift-add multiplier, EX/MEM register.
// Optional feature: define EX_FORWARD_EN to enable the EX/MEM and MEM/WB forwarding muxes.
module ex_stage #(
  parameter int unsigned CPU_BUS_SIZE = 32,
  parameter int unsigned MUL_ITER     = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    id_ex_valid,
  input  logic [3:0]              id_ex_alu_op,
  input  logic                    id_ex_alu_src,
  input  logic [CPU_BUS_SIZE-1:0] id_ex_rs_data,
  input  logic [CPU_BUS_SIZE-1:0] id_ex_rt_data,
  input  logic [CPU_BUS_SIZE-1:0] id_ex_imm,
  input  logic [4:0]              id_ex_rs,
  input  logic [4:0]              id_ex_rt,
  input  logic [4:0]              id_ex_rd,
  input  logic                    id_ex_mem_read,
  input  logic                    id_ex_mem_write,
  input  logic                    id_ex_mem_to_reg,
  input  logic                    id_ex_reg_write,
  input  logic                    id_ex_branch,
  input  logic                    id_ex_branch_bne,
  input  logic [1:0]              id_ex_branch_pridictor_bit,
  input  logic                    mem_wb_reg_write,
  input  logic [4:0]              mem_wb_rd,
  input  logic [CPU_BUS_SIZE-1:0] mem_wb_wb_data,
  input  logic                    pridictor_wrong,
  output logic                    ex_stall,
  output logic [CPU_BUS_SIZE-1:0] ex_mem_alu_result,
  output logic [CPU_BUS_SIZE-1:0] ex_mem_reg_read_data2,
  output logic [4:0]              ex_mem_rd,
  output logic                    ex_mem_mem_read,
  output logic                    ex_mem_mem_write,
  output logic                    ex_mem_mem_to_reg,
  output logic                    ex_mem_reg_write,
  output logic                    ex_mem_branch,
  output logic                    ex_mem_branch_bne,
  output logic [1:0]              ex_mem_branch_pridictor_bit
);

  localparam int unsigned W     = CPU_BUS_SIZE;
  localparam int unsigned CNT_W = (MUL_ITER > 1) ? $clog2(MUL_ITER) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_ITER - 1);

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_NOR = 4'd5;
  localparam logic [3:0] OP_SLT = 4'd6;
  localparam logic [3:0] OP_SLL = 4'd7;
  localparam logic [3:0] OP_SRL = 4'd8;
  localparam logic [3:0] OP_MUL = 4'd9;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} mul_state_t;

  mul_state_t       state;
  logic [W-1:0]     mul_a;
  logic [W-1:0]     mul_b;
  logic [W-1:0]     mul_acc;
  logic [CNT_W-1:0] mul_cnt;

  logic [W-1:0] fwd_a;
  logic [W-1:0] fwd_b;
  logic [W-1:0] op_b;
  logic [W-1:0] alu_result;
  logic [W-1:0] load_result;
  logic [4:0]   shamt;
  logic         is_mul;
  logic         load;

`ifdef EX_FORWARD_EN
  // EX/MEM has priority over MEM/WB; loads in EX/MEM are not ready yet and r0 never forwards
  always_comb begin
    fwd_a = id_ex_rs_data;
    if (ex_mem_reg_write && !ex_mem_mem_read && (ex_mem_rd != 5'd0) && (ex_mem_rd == id_ex_rs))
      fwd_a = ex_mem_alu_result;
    else if (mem_wb_reg_write && (mem_wb_rd != 5'd0) && (mem_wb_rd == id_ex_rs))
      fwd_a = mem_wb_wb_data;
  end

  always_comb begin
    fwd_b = id_ex_rt_data;
    if (ex_mem_reg_write && !ex_mem_mem_read && (ex_mem_rd != 5'd0) && (ex_mem_rd == id_ex_rt))
      fwd_b = ex_mem_alu_result;
    else if (mem_wb_reg_write && (mem_wb_rd != 5'd0) && (mem_wb_rd == id_ex_rt))
      fwd_b = mem_wb_wb_data;
  end
`else
  assign fwd_a = id_ex_rs_data;
  assign fwd_b = id_ex_rt_data;

  logic unused_fwd;
  assign unused_fwd = ^{mem_wb_reg_write, mem_wb_rd, mem_wb_wb_data, id_ex_rs, id_ex_rt};
`endif

  assign op_b   = id_ex_alu_src ? id_ex_imm : fwd_b;
  assign shamt  = id_ex_imm[10:6];
  assign is_mul = id_ex_valid && (id_ex_alu_op == OP_MUL);

  // Flush and reset both release the stall immediately
  assign ex_stall = !rst && !pridictor_wrong &&
                    ((state == S_BUSY) || ((state == S_IDLE) && is_mul));

  always_comb begin
    alu_result = '0;
    case (id_ex_alu_op)
      OP_ADD:  alu_result = fwd_a + op_b;
      OP_SUB:  alu_result = fwd_a - op_b;
      OP_AND:  alu_result = fwd_a & op_b;
      OP_OR:   alu_result = fwd_a | op_b;
      OP_XOR:  alu_result = fwd_a ^ op_b;
      OP_NOR:  alu_result = ~(fwd_a | op_b);
      OP_SLT:  alu_result = W'($signed(fwd_a) < $signed(op_b));
      OP_SLL:  alu_result = op_b << shamt;
      OP_SRL:  alu_result = op_b >> shamt;
      default: alu_result = '0;
    endcase
  end

  // Decide whether EX/MEM takes the current instruction or a bubble
  always_comb begin
    load        = 1'b0;
    load_result = alu_result;
    if (id_ex_valid && !pridictor_wrong) begin
      case (state)
        S_IDLE:  load = !is_mul;
        S_DONE: begin
          load        = 1'b1;
          load_result = mul_acc;
        end
        default: load = 1'b0;
      endcase
    end
  end

  // Shift-add multiplier sequencer
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      mul_a   <= '0;
      mul_b   <= '0;
      mul_acc <= '0;
      mul_cnt <= '0;
    end else if (pridictor_wrong) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (is_mul) begin
            mul_a   <= fwd_a;
            mul_b   <= op_b;
            mul_acc <= '0;
            mul_cnt <= '0;
            state   <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (mul_b[0]) mul_acc <= mul_acc + mul_a;
          mul_a   <= mul_a << 1;
          mul_b   <= mul_b >> 1;
          mul_cnt <= mul_cnt + CNT_W'(1);
          if (mul_cnt == CNT_LAST) state <= S_DONE;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst || !load) begin
      ex_mem_alu_result           <= '0;
      ex_mem_reg_read_data2       <= '0;
      ex_mem_rd                   <= '0;
      ex_mem_mem_read             <= 1'b0;
      ex_mem_mem_write            <= 1'b0;
      ex_mem_mem_to_reg           <= 1'b0;
      ex_mem_reg_write            <= 1'b0;
      ex_mem_branch               <= 1'b0;
      ex_mem_branch_bne           <= 1'b0;
      ex_mem_branch_pridictor_bit <= '0;
    end else begin
      ex_mem_alu_result           <= load_result;
      ex_mem_reg_read_data2       <= fwd_b;
      ex_mem_rd                   <= id_ex_rd;
      ex_mem_mem_read             <= id_ex_mem_read;
      ex_mem_mem_write            <= id_ex_mem_write;
      ex_mem_mem_to_reg           <= id_ex_mem_to_reg;
      ex_mem_reg_write            <= id_ex_reg_write;
      ex_mem_branch               <= id_ex_branch;
      ex_mem_branch_bne           <= id_ex_branch_bne;
      ex_mem_branch_pridictor_bit <= id_ex_branch_pridictor_bit;
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: vector table, forwarding, multiplier, flush and reset sequences.
module tb_ex_stage;

`ifdef EX_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  localparam logic [3:0] ADD = 4'd0, SUB = 4'd1, AND_ = 4'd2, OR_ = 4'd3, XOR_ = 4'd4,
                         NOR_ = 4'd5, SLT = 4'd6, SLL = 4'd7, SRL = 4'd8, MUL = 4'd9;
  // {mem_read, mem_write, mem_to_reg, reg_write, branch, bne}
  localparam logic [5:0] C_R = 6'b000100, C_LW = 6'b101100, C_SW = 6'b010000,
                         C_BEQ = 6'b000010, C_BNE = 6'b000011;

  logic        clk;
  logic        rst;
  logic        id_ex_valid;
  logic [3:0]  id_ex_alu_op;
  logic        id_ex_alu_src;
  logic [31:0] id_ex_rs_data, id_ex_rt_data, id_ex_imm;
  logic [4:0]  id_ex_rs, id_ex_rt, id_ex_rd;
  logic        id_ex_mem_read, id_ex_mem_write, id_ex_mem_to_reg, id_ex_reg_write;
  logic        id_ex_branch, id_ex_branch_bne;
  logic [1:0]  id_ex_branch_pridictor_bit;
  logic        mem_wb_reg_write;
  logic [4:0]  mem_wb_rd;
  logic [31:0] mem_wb_wb_data;
  logic        pridictor_wrong;
  logic        ex_stall;
  logic [31:0] ex_mem_alu_result, ex_mem_reg_read_data2;
  logic [4:0]  ex_mem_rd;
  logic        ex_mem_mem_read, ex_mem_mem_write, ex_mem_mem_to_reg, ex_mem_reg_write;
  logic        ex_mem_branch, ex_mem_branch_bne;
  logic [1:0]  ex_mem_branch_pridictor_bit;

  ex_stage #(.CPU_BUS_SIZE(32), .MUL_ITER(32)) dut (
    .clk(clk), .rst(rst), .id_ex_valid(id_ex_valid), .id_ex_alu_op(id_ex_alu_op),
    .id_ex_alu_src(id_ex_alu_src), .id_ex_rs_data(id_ex_rs_data), .id_ex_rt_data(id_ex_rt_data),
    .id_ex_imm(id_ex_imm), .id_ex_rs(id_ex_rs), .id_ex_rt(id_ex_rt), .id_ex_rd(id_ex_rd),
    .id_ex_mem_read(id_ex_mem_read), .id_ex_mem_write(id_ex_mem_write),
    .id_ex_mem_to_reg(id_ex_mem_to_reg), .id_ex_reg_write(id_ex_reg_write),
    .id_ex_branch(id_ex_branch), .id_ex_branch_bne(id_ex_branch_bne),
    .id_ex_branch_pridictor_bit(id_ex_branch_pridictor_bit),
    .mem_wb_reg_write(mem_wb_reg_write), .mem_wb_rd(mem_wb_rd), .mem_wb_wb_data(mem_wb_wb_data),
    .pridictor_wrong(pridictor_wrong), .ex_stall(ex_stall),
    .ex_mem_alu_result(ex_mem_alu_result), .ex_mem_reg_read_data2(ex_mem_reg_read_data2),
    .ex_mem_rd(ex_mem_rd), .ex_mem_mem_read(ex_mem_mem_read), .ex_mem_mem_write(ex_mem_mem_write),
    .ex_mem_mem_to_reg(ex_mem_mem_to_reg), .ex_mem_reg_write(ex_mem_reg_write),
    .ex_mem_branch(ex_mem_branch), .ex_mem_branch_bne(ex_mem_branch_bne),
    .ex_mem_branch_pridictor_bit(ex_mem_branch_pridictor_bit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] res;
    logic [31:0] d2;
    logic [4:0]  rd;
    logic [5:0]  ctrl;
    logic [1:0]  pred;
  } exp_t;

  typedef struct packed {
    logic        valid;
    logic [3:0]  op;
    logic        src;
    logic [31:0] a, b, imm;
    logic [4:0]  rs, rt, rd;
    logic [5:0]  ctrl;
    logic [1:0]  pred;
    logic [31:0] res;
  } vec_t;

  exp_t sbq[$];
  int   total = 0;
  int   bad   = 0;
  vec_t tbl[16];

  function automatic vec_t mk(logic valid, logic [3:0] op, logic src, logic [31:0] a, logic [31:0] b,
                              logic [31:0] imm, logic [4:0] rs, logic [4:0] rt, logic [4:0] rd,
                              logic [5:0] ctrl, logic [1:0] pred, logic [31:0] res);
    return '{valid, op, src, a, b, imm, rs, rt, rd, ctrl, pred, res};
  endfunction

  function automatic exp_t exp_of(vec_t v);
    exp_t e;
    e = '0;
    if (v.valid) e = '{v.res, v.b, v.rd, v.ctrl, v.pred};
    return e;
  endfunction

  function automatic exp_t cur();
    return '{ex_mem_alu_result, ex_mem_reg_read_data2, ex_mem_rd,
             {ex_mem_mem_read, ex_mem_mem_write, ex_mem_mem_to_reg, ex_mem_reg_write,
              ex_mem_branch, ex_mem_branch_bne}, ex_mem_branch_pridictor_bit};
  endfunction

  task automatic drive(input vec_t v);
    id_ex_valid   = v.valid;
    id_ex_alu_op  = v.op;
    id_ex_alu_src = v.src;
    id_ex_rs_data = v.a;
    id_ex_rt_data = v.b;
    id_ex_imm     = v.imm;
    id_ex_rs      = v.rs;
    id_ex_rt      = v.rt;
    id_ex_rd      = v.rd;
    {id_ex_mem_read, id_ex_mem_write, id_ex_mem_to_reg, id_ex_reg_write,
     id_ex_branch, id_ex_branch_bne} = v.ctrl;
    id_ex_branch_pridictor_bit = v.pred;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_exp(input string name, input exp_t act, input exp_t req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got res=%h d2=%h rd=%0d ctrl=%b pred=%b, want res=%h d2=%h rd=%0d ctrl=%b pred=%b",
               name, act.res, act.d2, act.rd, act.ctrl, act.pred,
               req.res, req.d2, req.rd, req.ctrl, req.pred);
    end
  endtask

  task automatic check_out(input string name);
    if (sbq.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s: scoreboard empty", name);
    end else begin
      check_exp(name, cur(), sbq.pop_front());
    end
  endtask

  task automatic check_int(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d", name, act, req);
    end
  endtask

  task automatic run_vec(input string name, input vec_t v);
    drive(v);
    sbq.push_back(exp_of(v));
    #1 check_int({name, "_stall"}, int'(ex_stall), 0);
    tick();
    check_out(name);
  endtask

  // Issue a MUL, count stall cycles, check bubbles while busy, then the product
  task automatic run_mul(input string name, input vec_t v);
    int n;
    drive(v);
    sbq.push_back(exp_of(v));
    #1 n = ex_stall ? 1 : 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      check_exp({name, "_bubble"}, cur(), '0);
      if (!ex_stall) break;
      n++;
    end
    check_int({name, "_stall_cycles"}, n, 33);
    tick();
    check_out(name);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    tbl[0]  = mk(1, ADD,  0, 32'd5,        32'd7,        32'h0,   1, 2, 10, C_R,   2'b10, 32'd12);
    tbl[1]  = mk(1, SLT,  0, 32'hFFFFFFFF, 32'd1,        32'h0,   1, 2, 11, C_R,   2'b00, 32'd1);
    tbl[2]  = mk(1, SUB,  0, 32'd10,       32'd3,        32'h0,   1, 2, 0,  C_BEQ, 2'b11, 32'd7);
    tbl[3]  = mk(1, AND_, 0, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h0,   1, 2, 12, C_R,   2'b00, 32'h00F000F0);
    tbl[4]  = mk(1, OR_,  0, 32'hF0000000, 32'h0000000F, 32'h0,   1, 2, 13, C_R,   2'b01, 32'hF000000F);
    tbl[5]  = mk(1, XOR_, 0, 32'hFFFF0000, 32'hFF00FF00, 32'h0,   1, 2, 14, C_R,   2'b00, 32'h00FFFF00);
    tbl[6]  = mk(1, NOR_, 0, 32'hF0F0F0F0, 32'h0F0F0F00, 32'h0,   1, 2, 15, C_R,   2'b00, 32'h0000000F);
    tbl[7]  = mk(1, SLL,  0, 32'h0,        32'd3,        32'h100, 1, 2, 16, C_R,   2'b00, 32'h30);
    tbl[8]  = mk(1, SRL,  0, 32'h0,        32'h80000000, 32'h7C0, 1, 2, 17, C_R,   2'b00, 32'h1);
    tbl[9]  = mk(1, ADD,  1, 32'd100,      32'h55,       32'hFFFFFFFF, 1, 2, 18, C_LW, 2'b01, 32'd99);
    tbl[10] = mk(1, SLT,  0, 32'd1,        32'hFFFFFFFF, 32'h0,   1, 2, 19, C_R,   2'b00, 32'd0);
    tbl[11] = mk(1, ADD,  0, 32'hFFFFFFFF, 32'd2,        32'h0,   1, 2, 20, C_R,   2'b00, 32'd1);
    tbl[12] = mk(1, 4'd12, 0, 32'd5,       32'd7,        32'h0,   1, 2, 21, C_R,   2'b00, 32'd0);
    tbl[13] = mk(0, ADD,  0, 32'd5,        32'd7,        32'h0,   1, 2, 22, C_R,   2'b10, 32'd12);
    tbl[14] = mk(1, SUB,  0, 32'd5,        32'd9,        32'h0,   1, 2, 0,  C_BNE, 2'b10, 32'hFFFFFFFC);
    tbl[15] = mk(1, ADD,  1, 32'h200,      32'hDEADBEEF, 32'd8,   1, 2, 0,  C_SW,  2'b00, 32'h208);

    // Reset with a MUL presented: stall must stay low, outputs clear
    rst = 1'b1;
    pridictor_wrong = 1'b0;
    mem_wb_reg_write = 1'b0;
    mem_wb_rd = '0;
    mem_wb_wb_data = '0;
    drive(mk(1, MUL, 0, 32'd3, 32'd5, 32'h0, 1, 2, 5, C_R, 2'b11, 32'd15));
    #1 check_int("reset_stall", int'(ex_stall), 0);
    tick();
    tick();
    check_exp("reset_exmem", cur(), '0);
    check_int("reset_stall2", int'(ex_stall), 0);
    id_ex_valid = 1'b0;
    rst = 1'b0;

    for (int i = 0; i < 16; i++) run_vec($sformatf("vec%0d", i), tbl[i]);

    // EX/MEM forwarding into rs
    run_vec("fwd_exmem_prod", mk(1, ADD, 0, 32'd5, 32'd7, 32'h0, 1, 2, 3, C_R, 2'b00, 32'd12));
    run_vec("fwd_exmem_use", mk(1, SUB, 0, 32'd0, 32'd2, 32'h0, 3, 4, 7, C_R, 2'b00,
                                FWD ? 32'd10 : 32'hFFFFFFFE));

    // MEM/WB forwarding into rt (operand B and store data)
    mem_wb_reg_write = 1'b1;
    mem_wb_rd = 5'd5;
    mem_wb_wb_data = 32'h100;
    drive(mk(1, ADD, 0, 32'd1, 32'd1, 32'h0, 6, 5, 8, C_R, 2'b00, 32'd0));
    sbq.push_back('{FWD ? 32'h101 : 32'h2, FWD ? 32'h100 : 32'h1, 5'd8, C_R, 2'b00});
    tick();
    check_out("fwd_memwb");

    // Both stages match rs: the younger EX/MEM value wins
    mem_wb_rd = 5'd8;
    mem_wb_wb_data = 32'h5000;
    drive(mk(1, ADD, 0, 32'd0, 32'd1, 32'h0, 8, 9, 10, C_R, 2'b00, 32'd0));
    sbq.push_back('{FWD ? 32'h102 : 32'h1, 32'h1, 5'd10, C_R, 2'b00});
    tick();
    check_out("fwd_priority");
    mem_wb_reg_write = 1'b0;

    // r0 is never forwarded from either stage
    run_vec("r0_write", mk(1, ADD, 0, 32'd5, 32'd7, 32'h0, 1, 2, 0, C_R, 2'b00, 32'd12));
    mem_wb_reg_write = 1'b1;
    mem_wb_rd = 5'd0;
    mem_wb_wb_data = 32'h999;
    run_vec("r0_use", mk(1, ADD, 0, 32'd0, 32'd0, 32'h0, 0, 0, 11, C_R, 2'b00, 32'd0));
    mem_wb_reg_write = 1'b0;

    // A load in EX/MEM is not forwarded
    run_vec("lw_prod", mk(1, ADD, 1, 32'h1000, 32'h0, 32'd4, 1, 2, 8, C_LW, 2'b00, 32'h1004));
    run_vec("lw_use", mk(1, ADD, 0, 32'h40, 32'h0, 32'h0, 8, 2, 9, C_R, 2'b00, 32'h40));

    run_mul("mul1", mk(1, MUL, 0, 32'h0000FFFF, 32'h00010001, 32'h0, 1, 2, 9, C_R, 2'b01, 32'hFFFFFFFF));
    run_mul("mul_imm_neg", mk(1, MUL, 1, 32'hFFFFFFFE, 32'h7, 32'd3, 1, 2, 12, C_R, 2'b00, 32'hFFFFFFFA));
    run_vec("after_mul", mk(1, ADD, 0, 32'd1, 32'd1, 32'h0, 1, 2, 13, C_R, 2'b00, 32'd2));

    // Flush at BUSY cycle 10 aborts the multiply
    drive(mk(1, MUL, 0, 32'd3, 32'd5, 32'h0, 1, 2, 14, C_R, 2'b00, 32'd15));
    for (int i = 0; i < 11; i++) tick();
    pridictor_wrong = 1'b1;
    #1 check_int("flush_busy_stall", int'(ex_stall), 0);
    tick();
    pridictor_wrong = 1'b0;
    id_ex_valid = 1'b0;
    #1 check_int("flush_idle_stall", int'(ex_stall), 0);
    check_exp("flush_busy_bubble", cur(), '0);
    run_vec("after_flush", mk(1, ADD, 0, 32'd2, 32'd3, 32'h0, 1, 2, 15, C_R, 2'b00, 32'd5));

    // Flush of a single-cycle op
    drive(mk(1, ADD, 0, 32'd4, 32'd4, 32'h0, 1, 2, 16, C_R, 2'b11, 32'd8));
    pridictor_wrong = 1'b1;
    sbq.push_back('0);
    tick();
    check_out("flush_alu");

    // Flush on the MUL issue cycle: no stall, stays IDLE
    drive(mk(1, MUL, 0, 32'd3, 32'd5, 32'h0, 1, 2, 16, C_R, 2'b00, 32'd15));
    #1 check_int("flush_issue_stall", int'(ex_stall), 0);
    tick();
    pridictor_wrong = 1'b0;
    id_ex_valid = 1'b0;
    #1 check_int("flush_issue_idle", int'(ex_stall), 0);
    check_exp("flush_issue_bubble", cur(), '0);

    // Reset (with simultaneous flush) mid-multiply
    drive(mk(1, MUL, 0, 32'd3, 32'd5, 32'h0, 1, 2, 17, C_R, 2'b00, 32'd15));
    for (int i = 0; i < 5; i++) tick();
    rst = 1'b1;
    pridictor_wrong = 1'b1;
    #1 check_int("rst_mul_stall", int'(ex_stall), 0);
    tick();
    check_exp("rst_mul_exmem", cur(), '0);
    rst = 1'b0;
    pridictor_wrong = 1'b0;
    run_vec("after_rst", mk(1, ADD, 0, 32'd6, 32'd1, 32'h0, 1, 2, 18, C_R, 2'b01, 32'd7));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
